led_pattern_scheduler: RTL and testbench



---
 rtl/led_pattern_scheduler_pkg.sv | 40 ++++
 rtl/led_pattern_scheduler_btn_sync.sv | 34 +++
 rtl/led_pattern_scheduler.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/led_pattern_scheduler_pkg.sv
// Shared encodings for the LED pattern scheduler.
//   state_e  : scheduler FSM state (also exported on o_state)
//   colour_e : colour channel currently carrying the pattern
//   BTN_*    : bit positions of the button commands
//   SW_*     : bit positions of the switch fields
package led_pattern_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLASH = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_e;

  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_COLOR = 2;
  localparam int BTN_STOP  = 3;

  localparam int SW_RATE_LO = 0;
  localparam int SW_RATE_HI = 1;
  localparam int SW_PAT     = 2;
  localparam int SW_AUTO    = 3;

  // RED -> GREEN -> BLUE -> RED; the unused code recovers to RED.
  function automatic colour_e next_colour(input colour_e c);
    case (c)
      COL_RED:   next_colour = COL_GREEN;
      COL_GREEN: next_colour = COL_BLUE;
      default:   next_colour = COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_btn_sync.sv
// Button synchroniser and rising-edge detector.
//   clock : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button levels
//   rise  : one-cycle command per button press (sync2 & ~prev)
// A level rising before edge k shows on rise after edge k+1.
module btn_edge_sync
  import led_pattern_scheduler_pkg::*;
#(
  parameter int NB_BUTTONS = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NB_BUTTONS-1:0] btn,
  output logic [NB_BUTTONS-1:0] rise
);

  logic [NB_BUTTONS-1:0] sync1, sync2, prev;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED pattern scheduler: start/pause/stop control, pattern tick generation,
// automatic shift/flash alternation and colour channel routing.
//   clock          : system clock
//   i_reset        : asynchronous active-low reset
//   i_btn          : [0] start, [1] pause/resume, [2] next colour, [3] stop
//   i_sw           : [1:0] rate, [2] pattern when auto off, [3] auto enable
//   i_led_shiftreg : shift-register pattern
//   i_led_flash    : flash pattern
//   o_valid        : one-cycle tick to the pattern generators
//   o_led          : selected pattern
//   o_led_r/g/b    : selected pattern on the active colour channel, else 0
//   o_state        : FSM state encoding
module led_pattern_scheduler
  import led_pattern_scheduler_pkg::*;
#(
  parameter int          NB_LED            = 4,
  parameter int          NB_BUTTONS        = 4,
  parameter int          NB_SW             = 4,
  parameter int          NB_CNT            = 32,
  parameter int unsigned TICK_BASE         = 32'h00FF_FFFF,
  parameter int          NB_STEP           = 3,
  parameter int          STEPS_PER_PATTERN = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_btn,
  input  logic [NB_SW-1:0]      i_sw,
  input  logic [NB_LED-1:0]     i_led_shiftreg,
  input  logic [NB_LED-1:0]     i_led_flash,
  output logic                  o_valid,
  output logic [NB_LED-1:0]     o_led,
  output logic [NB_LED-1:0]     o_led_r,
  output logic [NB_LED-1:0]     o_led_g,
  output logic [NB_LED-1:0]     o_led_b,
  output logic [1:0]            o_state
);

  localparam logic [NB_CNT-1:0]  TICK_MAX  = NB_CNT'(TICK_BASE);
  localparam logic [NB_STEP-1:0] STEP_LAST = NB_STEP'(STEPS_PER_PATTERN - 1);

  logic [NB_BUTTONS-1:0] cmd;
  state_e                state, state_nxt, resume_st;
  colour_e               colour;
  logic [NB_CNT-1:0]     tick_cnt, limit;
  logic [NB_STEP-1:0]    step;
  logic                  auto_en, sw_pat, running, step_wrap;
  logic [NB_LED-1:0]     led_src;

  btn_edge_sync #(.NB_BUTTONS(NB_BUTTONS)) u_btn_sync (
    .clock (clock),
    .rst_n (i_reset),
    .btn   (i_btn),
    .rise  (cmd)
  );

  assign auto_en   = i_sw[SW_AUTO];
  assign sw_pat    = i_sw[SW_PAT];
  assign running   = (state == ST_SHIFT) || (state == ST_FLASH);
  assign step_wrap = o_valid && (step == STEP_LAST);
  // Each rate step divides the period by four.
  assign limit     = TICK_MAX >> {i_sw[SW_RATE_HI:SW_RATE_LO], 1'b0};

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Stop beats pause beats start; pattern changes have the lowest priority.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cmd[BTN_START])
          state_nxt = (auto_en || !sw_pat) ? ST_SHIFT : ST_FLASH;
      ST_SHIFT, ST_FLASH: begin
        if (cmd[BTN_STOP])       state_nxt = ST_IDLE;
        else if (cmd[BTN_PAUSE]) state_nxt = ST_PAUSE;
        else if (!auto_en)       state_nxt = sw_pat ? ST_FLASH : ST_SHIFT;
        else if (step_wrap)      state_nxt = (state == ST_SHIFT) ? ST_FLASH : ST_SHIFT;
      end
      ST_PAUSE: begin
        if (cmd[BTN_STOP])       state_nxt = ST_IDLE;
        else if (cmd[BTN_PAUSE]) state_nxt = resume_st;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pattern to return to after a pause.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)
      resume_st <= ST_SHIFT;
    else if (running && state_nxt == ST_PAUSE)
      resume_st <= state;
  end

  assign o_state = state;

  // ---------------- colour ----------------
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)            colour <= COL_RED;
    else if (cmd[BTN_COLOR]) colour <= next_colour(colour);
  end

  // ---------------- tick generator ----------------
  // Frozen in PAUSE so a resume finishes the interrupted period.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      tick_cnt <= '0;
      o_valid  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT, ST_FLASH: begin
          if (tick_cnt >= limit) begin
            tick_cnt <= '0;
            o_valid  <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + NB_CNT'(1);
            o_valid  <= 1'b0;
          end
        end
        ST_PAUSE: o_valid <= 1'b0;
        default: begin
          tick_cnt <= '0;
          o_valid  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- step counter ----------------
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)
      step <= '0;
    else if (state_nxt != state || !auto_en)
      step <= '0;
    else if (running && o_valid)
      step <= step + NB_STEP'(1);
  end

  // ---------------- LED outputs ----------------
  always_comb begin
    led_src = '0;
    case (state)
      ST_SHIFT: led_src = i_led_shiftreg;
      ST_FLASH: led_src = i_led_flash;
      ST_PAUSE: led_src = o_led;
      default:  led_src = '0;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_led   <= '0;
      o_led_r <= '0;
      o_led_g <= '0;
      o_led_b <= '0;
    end else begin
      o_led   <= led_src;
      o_led_r <= (colour == COL_RED)   ? led_src : '0;
      o_led_g <= (colour == COL_GREEN) ? led_src : '0;
      o_led_b <= (colour == COL_BLUE)  ? led_src : '0;
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with TICK_BASE=7.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_scheduler;

  logic       clock = 1'b0;
  logic       i_reset;
  logic [3:0] i_btn, i_sw, i_led_shiftreg, i_led_flash;
  logic       o_valid;
  logic [3:0] o_led, o_led_r, o_led_g, o_led_b;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;
  int n, cnt, tmo;

  led_pattern_scheduler #(.TICK_BASE(7)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_btn          (i_btn),
    .i_sw           (i_sw),
    .i_led_shiftreg (i_led_shiftreg),
    .i_led_flash    (i_led_flash),
    .o_valid        (o_valid),
    .o_led          (o_led),
    .o_led_r        (o_led_r),
    .o_led_g        (o_led_g),
    .o_led_b        (o_led_b),
    .o_state        (o_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Falling edges until o_valid is seen (64 means it never came).
  task automatic next_valid(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!o_valid && k < 64);
  endtask

  task automatic press(input int b);
    i_btn[b] = 1'b1;
    repeat (3) @(negedge clock);
    i_btn[b] = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    i_reset = 1'b0; i_btn = '0; i_sw = '0;
    i_led_shiftreg = 4'b0101; i_led_flash = 4'b1010;
    repeat (3) @(negedge clock);
    i_reset = 1'b1;

    // reset and idle
    chk("rst_state", o_state, 0);
    chk("rst_led", {o_led, o_led_r, o_led_g, o_led_b}, 0);
    chk("rst_valid", o_valid, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clock);
      if (o_valid || o_led != 0 || o_state != 0) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // start: effect two edges after the press
    i_btn[0] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("start_k1", o_state, 0);
    @(negedge clock);
    chk("start_k2", o_state, 1);
    i_btn[0] = 1'b0;
    next_valid(n); chk("first_tick", n, 8);
    next_valid(n); chk("period8", n, 8);
    chk("shift_led", o_led, 4'b0101);
    chk("shift_rgb", {o_led_r, o_led_g, o_led_b}, 12'h500);
    i_sw = 4'b0001;
    next_valid(n); chk("period2a", n, 2);
    next_valid(n); chk("period2b", n, 2);

    // auto-advance
    @(negedge clock);
    i_sw = 4'b1001;
    tmo = 0;
    repeat (8) begin next_valid(n); if (n >= 64) tmo++; end
    chk("auto_shift_hold", o_state, 1);
    @(negedge clock);
    chk("auto_to_flash", o_state, 2);
    @(negedge clock);
    chk("auto_flash_led", o_led, 4'b1010);
    chk("auto_flash_tick", o_valid, 1);
    repeat (7) begin next_valid(n); if (n >= 64) tmo++; end
    chk("auto_flash_hold", o_state, 2);
    @(negedge clock);
    chk("auto_to_shift", o_state, 1);
    chk("auto_timeouts", tmo, 0);

    // pause / resume in FLASH
    i_sw = 4'b0100;
    next_valid(n);
    chk("sel_flash", o_state, 2);
    i_btn[1] = 1'b1;
    repeat (3) @(negedge clock);
    i_btn[1] = 1'b0;
    chk("pause_state", o_state, 3);
    i_led_flash = 4'b1111;
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (o_valid) cnt++;
    end
    chk("pause_no_tick", cnt, 0);
    chk("pause_frozen", o_led, 4'b1010);
    chk("pause_hold", o_state, 3);
    i_btn[1] = 1'b1;
    repeat (3) @(negedge clock);
    i_btn[1] = 1'b0;
    chk("resume_state", o_state, 2);
    next_valid(n); chk("resume_remaining", n, 5);
    chk("resume_led", o_led, 4'b1111);

    // colour routing
    i_led_flash = 4'b1100;
    press(2);
    chk("col_green", {o_led, o_led_r, o_led_g, o_led_b}, 16'hC0C0);
    press(2);
    chk("col_blue", {o_led, o_led_r, o_led_g, o_led_b}, 16'hC00C);
    press(2);
    chk("col_red", {o_led, o_led_r, o_led_g, o_led_b}, 16'hCC00);

    // stop and pause together: stop wins
    i_btn = 4'b1010;
    repeat (3) @(negedge clock);
    i_btn = '0;
    chk("stop_state", o_state, 0);
    @(negedge clock);
    chk("stop_led", {o_led, o_led_r, o_led_g, o_led_b}, 0);

    // asynchronous reset mid-run
    i_sw = 4'b0000;
    press(0);
    repeat (12) @(negedge clock);
    chk("run_shift", o_state, 1);
    chk("run_led", o_led_r, 4'b0101);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_led", {o_led, o_led_r, o_led_g, o_led_b}, 0);
    chk("arst_valid", o_valid, 0);
    @(negedge clock);
    i_reset = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clock);
      if (o_valid || o_state != 0) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
